// File: rtl/multu_hilo_unit_if.sv
// Operation/operand/result bundle between ALU control and the HI/LO multiplier.
interface multu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       MULTUOperation;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;

  modport master (
    output MULTUOperation, dataA, dataB,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  MULTUOperation, dataA, dataB,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier feeding the HI/LO pair.
// One iteration per clock; the finished product waits in DONE for a HILO commit.
module multu_hilo_unit #(
  parameter int          WIDTH      = 32,
  parameter logic [5:0]  MULTU_CODE = 6'b011001,
  parameter logic [5:0]  HILO_CODE  = 6'b111111
) (
  input  logic               Clk,
  input  logic               Reset_n,
  multu_hilo_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     prod_q,  prod_d;   // {carry, upper, lower}
  logic [WIDTH-1:0]     hi_q,    hi_d;
  logic [WIDTH-1:0]     lo_q,    lo_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [WIDTH:0]       upper;
  logic                 start;

  // A new multiply is accepted from IDLE or DONE, never mid-iteration.
  assign start = (bus.MULTUOperation == MULTU_CODE) && (state_q != RUN);

  // Next-state, datapath iteration and HI/LO commit.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    upper   = prod_q[2*WIDTH:WIDTH];
    if (start) begin
      mcand_d = bus.dataA;
      prod_d  = {{(WIDTH+1){1'b0}}, bus.dataB};
      count_d = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (prod_q[0]) upper = prod_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
          prod_d  = {upper, prod_q[WIDTH-1:0]} >> 1;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH-1)) state_d = DONE;
        end
        DONE: begin
          if (bus.MULTUOperation == HILO_CODE) begin
            hi_d    = prod_q[2*WIDTH-1:WIDTH];
            lo_d    = prod_q[WIDTH-1:0];
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule
